statelink_axis_reg_slice: RTL and testbench

STATELINK_AXIS_REG_SLICE -- requirements
Module: statelink_axis_reg_slice

---
 rtl/statelink_axis_pkg.sv | 19 +
 rtl/statelink_axis_reg_slice_if.sv | 21 ++
 rtl/statelink_axis_skid.sv | 85 ++++++++
 rtl/statelink_axis_reg_slice.sv | 96 +++++++++
 tb/tb_statelink_axis_reg_slice.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/statelink_axis_pkg.sv
// Shared types and helpers for the statelink AXI-Stream register slice.
// Holds the per-channel stop FSM encoding and the tkeep width derivation.
// Ports: none (package).
package statelink_axis_pkg;

  // Per-channel stop sequencing: RUN -> (FLUSH) -> DRAIN -> STOPPED
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_STOPPED = 2'd3
  } ch_state_e;

  // One tkeep bit per tdata byte
  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/statelink_axis_reg_slice_if.sv
// Multi-channel AXI-Stream bundle; channel c uses slice c of every vector.
// No latency (wiring only); tready flows against the data direction.
// Ports: tdata/tkeep/tlast/tvalid/tready, modports master (drives beats) and slave (accepts beats).
interface statelink_axis_reg_slice_if
  import statelink_axis_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH);

  logic [NUM_CH*DATA_WIDTH-1:0] tdata;
  logic [NUM_CH*KEEP_WIDTH-1:0] tkeep;
  logic [NUM_CH-1:0]            tlast;
  logic [NUM_CH-1:0]            tvalid;
  logic [NUM_CH-1:0]            tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/statelink_axis_skid.sv
// One channel of 2-entry skid buffer: output register plus one skid register.
// Latency 1 cycle when empty; full throughput while m_tready_i is high.
// Backpressure: s_tready_o is a flop, low whenever the skid holds a beat or admit_i is low.
// Ports: clk_i/rst_i, s_* slave beat in, m_* master beat out, admit_i (next-cycle admission),
//        accept_o (slave transfer this cycle), empty_o (both registers empty).
module statelink_axis_skid
  import statelink_axis_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
  input  logic                  s_tlast_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_tkeep_o,
  output logic                  m_tlast_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  input  logic                  admit_i,
  output logic                  accept_o,
  output logic                  empty_o
);
  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [PW-1:0] out_q, out_d, skid_q, skid_d;
  logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic          rdy_q, rdy_d;
  logic [PW-1:0] in_pld;

  assign in_pld   = {s_tlast_i, s_tkeep_i, s_tdata_i};
  assign accept_o = s_tvalid_i && rdy_q;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || m_tready_i) begin
      // Output slot frees up this edge: the skid beat is older, so it goes first.
      // rdy_q is low whenever the skid is full, so no new beat can arrive alongside.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept_o) begin
        out_d     = in_pld;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept_o) begin
      skid_d     = in_pld;
      skid_vld_d = 1'b1;
    end
    // Ready is computed from next-state values so it stays a pure flop output
    rdy_d = !skid_vld_d && admit_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign {m_tlast_o, m_tkeep_o, m_tdata_o} = out_q;
  assign m_tvalid_o = out_vld_q;
  assign s_tready_o = rdy_q;
  assign empty_o    = !out_vld_q && !skid_vld_q;

endmodule

// File: rtl/statelink_axis_reg_slice.sv
// NUM_CH independent AXI-Stream register slices with per-channel graceful stop (decouple/stop_ack).
// Latency 1 cycle, 1 beat/cycle/channel; all outputs registered.
// Backpressure: s_axis.tready drops when a channel's skid fills or its stop FSM blocks input.
// Ports: axis_clk, axis_rst (sync, active high), s_axis (slave), m_axis (master), decouple in, stop_ack out.
module statelink_axis_reg_slice
  import statelink_axis_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst,
  statelink_axis_reg_slice_if.slave  s_axis,
  statelink_axis_reg_slice_if.master m_axis,
  input  logic [NUM_CH-1:0]          decouple,
  output logic [NUM_CH-1:0]          stop_ack
);
  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH);

  logic [NUM_CH*DATA_WIDTH-1:0] m_dat;
  logic [NUM_CH*KEEP_WIDTH-1:0] m_kep;
  logic [NUM_CH-1:0]            m_lst, m_vld, s_rdy;

  assign m_axis.tdata  = m_dat;
  assign m_axis.tkeep  = m_kep;
  assign m_axis.tlast  = m_lst;
  assign m_axis.tvalid = m_vld;
  assign s_axis.tready = s_rdy;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e state_q, state_d;
    logic      in_pkt_q, in_pkt_d;
    logic      ack_q, admit_d, accept, empty;

    statelink_axis_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk_i      (axis_clk),
      .rst_i      (axis_rst),
      .s_tdata_i  (s_axis.tdata[c*DATA_WIDTH +: DATA_WIDTH]),
      .s_tkeep_i  (s_axis.tkeep[c*KEEP_WIDTH +: KEEP_WIDTH]),
      .s_tlast_i  (s_axis.tlast[c]),
      .s_tvalid_i (s_axis.tvalid[c]),
      .s_tready_o (s_rdy[c]),
      .m_tdata_o  (m_dat[c*DATA_WIDTH +: DATA_WIDTH]),
      .m_tkeep_o  (m_kep[c*KEEP_WIDTH +: KEEP_WIDTH]),
      .m_tlast_o  (m_lst[c]),
      .m_tvalid_o (m_vld[c]),
      .m_tready_i (m_axis.tready[c]),
      .admit_i    (admit_d),
      .accept_o   (accept),
      .empty_o    (empty)
    );

    always_comb begin
      in_pkt_d = in_pkt_q;
      state_d  = state_q;
      if (accept) begin
        in_pkt_d = !s_axis.tlast[c];
      end
      // Decisions use in_pkt_d so a beat accepted on the decouple edge is
      // accounted for; otherwise a packet could start and then be blocked.
      unique case (state_q)
        ST_RUN: begin
          if (decouple[c]) state_d = in_pkt_d ? ST_FLUSH : ST_DRAIN;
        end
        ST_FLUSH: begin
          if (!decouple[c])                       state_d = ST_RUN;
          else if (accept && s_axis.tlast[c])     state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!decouple[c])                       state_d = ST_RUN;
          else if (empty)                         state_d = ST_STOPPED;
        end
        ST_STOPPED: begin
          if (!decouple[c])                       state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
      admit_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
        state_q  <= ST_RUN;
        in_pkt_q <= 1'b0;
        ack_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        in_pkt_q <= in_pkt_d;
        ack_q    <= (state_d == ST_STOPPED);
      end
    end

    assign stop_ack[c] = ack_q;
  end

endmodule

// File: tb/tb_statelink_axis_reg_slice.sv
// Testbench for statelink_axis_reg_slice (NUM_CH=4, DATA_WIDTH=64).
// Directed streaming/backpressure/decouple/reset sequences, then random traffic.
// A negedge monitor scoreboards every slave beat against every master beat per channel.
module tb_statelink_axis_reg_slice;
  localparam int NC = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          axis_clk;
  logic          axis_rst;
  logic [NC-1:0] decouple;
  logic [NC-1:0] stop_ack;
  logic [NC-1:0] s_fired;

  int n_chk  = 0;
  int n_err  = 0;
  int rx_cnt = 0;
  int k0     = 0;

  beat_t sb[NC][$];

  statelink_axis_reg_slice_if #(.NUM_CH(NC), .DATA_WIDTH(DW)) s_if ();
  statelink_axis_reg_slice_if #(.NUM_CH(NC), .DATA_WIDTH(DW)) m_if ();

  statelink_axis_reg_slice #(.NUM_CH(NC), .DATA_WIDTH(DW)) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .s_axis   (s_if.slave),
    .m_axis   (m_if.master),
    .decouple (decouple),
    .stop_ack (stop_ack)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic set_beat(input int c, input logic v, input logic [DW-1:0] d,
                          input logic [KW-1:0] k, input logic l);
    s_if.tvalid[c]         = v;
    s_if.tdata[c*DW +: DW] = d;
    s_if.tkeep[c*KW +: KW] = k;
    s_if.tlast[c]          = l;
  endtask

  // Keeps channel 0 streaming single-beat packets while other channels are exercised
  task automatic nxt0();
    set_beat(0, 1'b1, 64'h100 + 64'(k0), 8'hFF, 1'b1);
    k0++;
  endtask

  function automatic logic [DW-1:0] m_dat(input int c);
    return m_if.tdata[c*DW +: DW];
  endfunction

  // Transfers are decided by values stable at the negedge before the edge
  always @(negedge axis_clk) begin
    if (axis_rst) begin
      s_fired = '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        s_fired[c] = s_if.tvalid[c] && s_if.tready[c];
        if (s_fired[c])
          sb[c].push_back('{last: s_if.tlast[c], keep: s_if.tkeep[c*KW +: KW],
                            data: s_if.tdata[c*DW +: DW]});
        if (m_if.tvalid[c] && m_if.tready[c]) begin
          chk("sb_nonempty", 64'(sb[c].size() != 0), 64'd1);
          if (sb[c].size() != 0) begin
            beat_t b;
            b = sb[c].pop_front();
            chk("sb_data", m_if.tdata[c*DW +: DW], b.data);
            chk("sb_keep", 64'(m_if.tkeep[c*KW +: KW]), 64'(b.keep));
            chk("sb_last", 64'(m_if.tlast[c]), 64'(b.last));
            rx_cnt++;
          end
        end
        if (stop_ack[c]) chk("ack_vs_vld", 64'(m_if.tvalid[c]), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_rst     = 1'b1;
    decouple     = '0;
    m_if.tready  = '0;
    for (int c = 0; c < NC; c++) set_beat(c, 1'b0, '0, '0, 1'b0);
    repeat (3) step();

    // Reset state
    chk("rst_mvld",  64'(m_if.tvalid), 64'd0);
    chk("rst_mdat",  64'(|m_if.tdata), 64'd0);
    chk("rst_mkeep", 64'(m_if.tkeep), 64'd0);
    chk("rst_mlast", 64'(m_if.tlast), 64'd0);
    chk("rst_srdy",  64'(s_if.tready), 64'd0);
    chk("rst_ack",   64'(stop_ack), 64'd0);
    axis_rst = 1'b0;
    step();
    chk("rdy_after_rst", 64'(s_if.tready), 64'hF);

    // Streaming on ch0
    m_if.tready = '1;
    for (int i = 1; i <= 8; i++) begin
      set_beat(0, 1'b1, 64'(i), 8'hFF, i == 8);
      step();
      chk("str_vld", 64'(m_if.tvalid[0]), 64'd1);
      chk("str_dat", m_dat(0), 64'(i));
      chk("str_rdy", 64'(s_if.tready[0]), 64'd1);
    end
    set_beat(0, 1'b0, '0, '0, 1'b0);
    step();
    chk("str_idle", 64'(m_if.tvalid[0]), 64'd0);

    // Backpressure on ch0
    m_if.tready[0] = 1'b0;
    set_beat(0, 1'b1, 64'hA, 8'hFF, 1'b1);
    step();
    chk("bp_a_dat", m_dat(0), 64'hA);
    chk("bp_a_rdy", 64'(s_if.tready[0]), 64'd1);
    set_beat(0, 1'b1, 64'hB, 8'hFF, 1'b1);
    step();
    chk("bp_b_dat", m_dat(0), 64'hA);
    chk("bp_b_rdy", 64'(s_if.tready[0]), 64'd0);
    set_beat(0, 1'b0, '0, '0, 1'b0);
    step();
    chk("bp_hold_dat", m_dat(0), 64'hA);
    chk("bp_hold_vld", 64'(m_if.tvalid[0]), 64'd1);
    m_if.tready[0] = 1'b1;
    step();
    chk("bp_rel_dat", m_dat(0), 64'hB);
    chk("bp_rel_rdy", 64'(s_if.tready[0]), 64'd1);
    step();
    chk("bp_empty", 64'(m_if.tvalid[0]), 64'd0);

    // Decouple ch1 mid-packet while ch0 keeps streaming
    for (int i = 0; i < 3; i++) begin
      set_beat(1, 1'b1, 64'h11 + 64'(i), 8'hFF, 1'b0);
      nxt0();
      step();
      chk("pkt_rdy1", 64'(s_if.tready[1]), 64'd1);
    end
    set_beat(1, 1'b0, '0, '0, 1'b0);
    decouple[1] = 1'b1;
    nxt0();
    step();
    chk("flush_rdy1", 64'(s_if.tready[1]), 64'd1);
    set_beat(1, 1'b1, 64'h14, 8'hFF, 1'b0);
    nxt0();
    step();
    chk("flush_rdy1b", 64'(s_if.tready[1]), 64'd1);
    set_beat(1, 1'b1, 64'h15, 8'hFF, 1'b1);
    nxt0();
    step();
    chk("drain_rdy1", 64'(s_if.tready[1]), 64'd0);
    chk("drain_dat1", m_dat(1), 64'h15);
    chk("drain_ack1", 64'(stop_ack[1]), 64'd0);
    set_beat(1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 8 && !stop_ack[1]; i++) begin
      nxt0();
      step();
    end
    chk("stop_ack1", 64'(stop_ack[1]), 64'd1);
    chk("stop_vld1", 64'(m_if.tvalid[1]), 64'd0);
    chk("ch0_rdy", 64'(s_if.tready[0]), 64'd1);
    chk("ch0_ack", 64'(stop_ack[0]), 64'd0);
    set_beat(0, 1'b0, '0, '0, 1'b0);
    decouple[1] = 1'b0;
    step();
    chk("resume_ack1", 64'(stop_ack[1]), 64'd0);
    chk("resume_rdy1", 64'(s_if.tready[1]), 64'd1);

    // Decouple all idle channels
    step();
    decouple = '1;
    step();
    step();
    chk("idle_ack", 64'(stop_ack), 64'hF);
    chk("idle_vld", 64'(m_if.tvalid), 64'd0);
    chk("idle_rdy", 64'(s_if.tready), 64'd0);
    decouple = '0;
    step();
    chk("idle_resume_ack", 64'(stop_ack), 64'd0);
    chk("idle_resume_rdy", 64'(s_if.tready), 64'hF);

    // Reset while ch2 is draining with both registers full
    m_if.tready = 4'b1011;
    set_beat(2, 1'b1, 64'h21, 8'hFF, 1'b1);
    step();
    set_beat(2, 1'b1, 64'h22, 8'hFF, 1'b1);
    step();
    chk("skid_full2", 64'(s_if.tready[2]), 64'd0);
    set_beat(2, 1'b0, '0, '0, 1'b0);
    decouple[2] = 1'b1;
    step();
    step();
    chk("drain_ack2", 64'(stop_ack[2]), 64'd0);
    chk("drain_vld2", 64'(m_if.tvalid[2]), 64'd1);
    axis_rst = 1'b1;
    for (int c = 0; c < NC; c++) sb[c].delete();
    step();
    chk("mid_rst_vld", 64'(m_if.tvalid), 64'd0);
    chk("mid_rst_ack", 64'(stop_ack), 64'd0);
    chk("mid_rst_rdy", 64'(s_if.tready), 64'd0);
    axis_rst    = 1'b0;
    decouple    = '0;
    m_if.tready = '1;
    repeat (5) step();
    chk("no_stale_vld", 64'(m_if.tvalid), 64'd0);
    chk("post_rst_rdy", 64'(s_if.tready), 64'hF);

    // Random traffic, with occasional decouple toggles
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (!s_if.tvalid[c] || s_fired[c]) begin
          if ($urandom_range(0, 3) != 0)
            set_beat(c, 1'b1, {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 1)));
          else
            set_beat(c, 1'b0, '0, '0, 1'b0);
        end
        m_if.tready[c] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 99) == 0) decouple[c] = ~decouple[c];
      end
      step();
    end

    // Let pending beats complete, then everything must be accounted for
    decouple    = '0;
    m_if.tready = '1;
    for (int i = 0; i < 200; i++) begin
      for (int c = 0; c < NC; c++)
        if (s_fired[c]) set_beat(c, 1'b0, '0, '0, 1'b0);
      step();
      if (s_if.tvalid == '0 && m_if.tvalid == '0) break;
    end
    chk("rnd_idle", 64'({s_if.tvalid, m_if.tvalid}), 64'd0);
    for (int c = 0; c < NC; c++) chk("sb_left", 64'(sb[c].size()), 64'd0);
    chk("rnd_rx_cnt", 64'(rx_cnt > 2000), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
